// File: rtl/square_asm.sv
// Shift-and-add squarer sequenced by an IDLE/LOAD/CHECK/ADD/SHIFT/DONE state machine; all state moves on the falling clk edge.
// Define SQUARE_EARLY_EXIT_EN to leave the loop as soon as the remaining multiplier bits are all zero.
module square_asm #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_A,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    // count must be able to reach WIDTH after the final shift
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   m_reg, m_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic [WIDTH-1:0]     b_reg, b_next;
    logic [WIDTH-1:0]     b_shifted;
    logic [CW-1:0]        count_reg, count_next;
    logic                 last_iter;
    logic                 finish_now;

    assign b_shifted = b_reg >> 1;
    assign last_iter = (count_reg == CW'(WIDTH - 1));

`ifdef SQUARE_EARLY_EXIT_EN
    assign finish_now = last_iter || (b_shifted == '0);
`else
    assign finish_now = last_iter;
`endif

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= IDLE;
            m_reg      <= '0;
            acc_reg    <= '0;
            b_reg      <= '0;
            count_reg  <= '0;
            result_reg <= '0;
        end else begin
            state      <= state_next;
            m_reg      <= m_next;
            acc_reg    <= acc_next;
            b_reg      <= b_next;
            count_reg  <= count_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state;
        m_next      = m_reg;
        acc_next    = acc_reg;
        b_next      = b_reg;
        count_next  = count_reg;
        result_next = result_reg;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                m_next     = {{WIDTH{1'b0}}, in_A};
                b_next     = in_A;
                acc_next   = '0;
                count_next = '0;
                state_next = CHECK;
            end
            CHECK: begin
                state_next = b_reg[0] ? ADD : SHIFT;
            end
            ADD: begin
                acc_next   = acc_reg + m_reg;
                state_next = SHIFT;
            end
            SHIFT: begin
                m_next     = m_reg << 1;
                b_next     = b_shifted;
                count_next = count_reg + CW'(1);
                // acc_reg already holds any ADD from this iteration
                if (finish_now) begin
                    result_next = acc_reg;
                    state_next  = DONE;
                end else begin
                    state_next = CHECK;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result = result_reg;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule
